// File: rtl/icache_fetcher.sv
// Instruction fetch stage: serves current_pc from a direct-mapped, one-instruction-per-line
// cache, falling back to a valid/ready program memory read on a miss.
module icache_fetcher #(
   parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
   parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
   parameter int unsigned CACHE_LINES           = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             cache_flush,
   output logic                             mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
   input  logic                             mem_read_ready,
   input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [15:0]                      hit_count,
   output logic [15:0]                      miss_count
);

   localparam int unsigned IDX_BITS = $clog2(CACHE_LINES);
   localparam int unsigned TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

   localparam logic [2:0] CS_FETCH  = 3'b001;
   localparam logic [2:0] CS_DECODE = 3'b010;

   typedef enum logic [2:0] {
      StIdle     = 3'b000,
      StFetching = 3'b001,
      StFetched  = 3'b010
   } state_e;

   state_e                             r_state, w_state_d;
   logic                               r_req, w_req_d;
   logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_pc, w_pc_d;
   logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr, w_instr_d;
   logic [15:0]                        r_hit_cnt, w_hit_cnt_d;
   logic [15:0]                        r_miss_cnt, w_miss_cnt_d;

   logic [CACHE_LINES-1:0]             r_valid;
   logic [TAG_BITS-1:0]                r_tag  [CACHE_LINES];
   logic [PROGRAM_MEM_DATA_BITS-1:0]   r_data [CACHE_LINES];

   logic [IDX_BITS-1:0]                w_idx;
   logic [TAG_BITS-1:0]                w_tag;
   logic [IDX_BITS-1:0]                w_fill_idx;
   logic [TAG_BITS-1:0]                w_fill_tag;
   logic                               w_hit;
   logic                               w_fill;

   assign w_idx      = current_pc[IDX_BITS-1:0];
   assign w_tag      = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
   assign w_fill_idx = r_pc[IDX_BITS-1:0];
   assign w_fill_tag = r_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];

   // A same-cycle flush wins over the lookup, so the fetch is forced to miss.
   assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !cache_flush;

   always_comb begin
      w_state_d    = r_state;
      w_req_d      = r_req;
      w_pc_d       = r_pc;
      w_instr_d    = r_instr;
      w_hit_cnt_d  = r_hit_cnt;
      w_miss_cnt_d = r_miss_cnt;
      w_fill       = 1'b0;
      case (r_state)
         StIdle: begin
            if (core_state == CS_FETCH) begin
               if (w_hit) begin
                  w_instr_d   = r_data[w_idx];
                  w_hit_cnt_d = (r_hit_cnt == 16'hFFFF) ? r_hit_cnt : r_hit_cnt + 16'd1;
                  w_state_d   = StFetched;
               end else begin
                  w_req_d      = 1'b1;
                  w_pc_d       = current_pc;
                  w_miss_cnt_d = (r_miss_cnt == 16'hFFFF) ? r_miss_cnt : r_miss_cnt + 16'd1;
                  w_state_d    = StFetching;
               end
            end
         end
         StFetching: begin
            if (mem_read_ready) begin
               w_instr_d = mem_read_data;
               w_req_d   = 1'b0;
               w_fill    = 1'b1;
               w_state_d = StFetched;
            end
         end
         StFetched: begin
            if (core_state == CS_DECODE) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= StIdle;
         r_req      <= 1'b0;
         r_pc       <= '0;
         r_instr    <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_req      <= w_req_d;
         r_pc       <= w_pc_d;
         r_instr    <= w_instr_d;
         r_hit_cnt  <= w_hit_cnt_d;
         r_miss_cnt <= w_miss_cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (cache_flush) begin
         r_valid <= '0;
      end else if (w_fill) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // Tag/data need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= mem_read_data;
      end
   end

   assign mem_read_valid   = r_req;
   assign mem_read_address = r_pc;
   assign fetcher_state    = r_state;
   assign instruction      = r_instr;
   assign hit_count        = r_hit_cnt;
   assign miss_count       = r_miss_cnt;

endmodule
